// File: rtl/fir_out_buffer.sv
// Output buffer for a FIR filter: decimates the settled filter results and
// queues them in a small circular FIFO for a valid/ready consumer.
module fir_out_buffer #(
  parameter int DEPTH = 8,
  parameter int DECIM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic        fir_valid,
  input  logic [15:0] fir_d,
  input  logic        clr,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [6:0]  out_level,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [6:0]    FULL_LVL = 7'(DEPTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);

  logic          dv_d;
  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   mem [DEPTH];

  logic new_sample;
  logic push;
  logic pop;
  logic full;
  logic accept;

  // The filter result settles one cycle after its strobe, so the delayed
  // strobe qualifies fir_d.
  assign new_sample = dv_d & fir_valid;
  assign push       = new_sample & (phase == '0);

  // Handshake: out_valid means the head is valid; the head is consumed on any
  // edge where out_valid & out_ready, and stays stable until then.
  assign out_valid  = (out_level != 7'd0);
  assign pop        = out_valid & out_ready;
  assign full       = (out_level == FULL_LVL);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign accept     = push & (~full | pop);
  assign out_data   = out_valid ? mem[rd_ptr] : 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_d      <= 1'b0;
      phase     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_level <= 7'd0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
    end else if (clr) begin
      dv_d      <= 1'b0;
      phase     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_level <= 7'd0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      dv_d <= data_valid;

      if (!fir_valid) begin
        phase <= '0;
      end else if (new_sample) begin
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end

      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({accept, pop})
        2'b10:   out_level <= out_level + 7'd1;
        2'b01:   out_level <= out_level - 7'd1;
        default: out_level <= out_level;
      endcase

      if (push & ~accept) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  // Storage is not reset; it is only visible through out_data while out_valid.
  always_ff @(posedge clk) begin
    if (accept && !clr && !rst) begin
      mem[wr_ptr] <= fir_d;
    end
  end

endmodule

// File: tb/tb_fir_out_buffer.sv
// Bench for fir_out_buffer: two instances (DECIM=2 and DECIM=1) share stimulus
// and are compared every cycle against queue-based models.
module tb_fir_out_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic        fir_valid = 1'b0;
  logic [15:0] fir_d = 16'd0;
  logic        clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        ov2, ov1, of2, of1;
  logic [15:0] od2, od1;
  logic [6:0]  lvl2, lvl1;
  logic [7:0]  dc2, dc1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q2[$];
  logic [15:0] exp_q1[$];
  bit m_dvd = 0;
  int ns2 = 0, ns1 = 0;
  bit ovf2 = 0, ovf1 = 0;
  int drop2 = 0, drop1 = 0;

  fir_out_buffer #(.DEPTH(DEPTH), .DECIM(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .fir_valid(fir_valid),
    .fir_d(fir_d), .clr(clr), .out_valid(ov2), .out_data(od2),
    .out_ready(out_ready), .out_level(lvl2), .overflow(of2), .drop_cnt(dc2)
  );

  fir_out_buffer #(.DEPTH(DEPTH), .DECIM(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .fir_valid(fir_valid),
    .fir_d(fir_d), .clr(clr), .out_valid(ov1), .out_data(od1),
    .out_ready(out_ready), .out_level(lvl1), .overflow(of1), .drop_cnt(dc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: kept samples are every DECIM-th qualified result since
  // fir_valid rose; a full queue drops unless the consumer takes one that cycle.
  task automatic model_step();
    bit ns_now, keep, full, popped;
    if (rst || clr) begin
      exp_q2.delete(); exp_q1.delete();
      m_dvd = 0; ns2 = 0; ns1 = 0;
      ovf2 = 0; ovf1 = 0; drop2 = 0; drop1 = 0;
    end else begin
      ns_now = m_dvd && fir_valid;

      keep   = ns_now && (ns2 % 2 == 0);
      full   = exp_q2.size() == DEPTH;
      popped = exp_q2.size() != 0 && out_ready;
      if (popped) void'(exp_q2.pop_front());
      if (keep) begin
        if (!full || popped) exp_q2.push_back(fir_d);
        else begin ovf2 = 1; if (drop2 < 255) drop2++; end
      end
      ns2 = fir_valid ? ns2 + int'(ns_now) : 0;

      keep   = ns_now;
      full   = exp_q1.size() == DEPTH;
      popped = exp_q1.size() != 0 && out_ready;
      if (popped) void'(exp_q1.pop_front());
      if (keep) begin
        if (!full || popped) exp_q1.push_back(fir_d);
        else begin ovf1 = 1; if (drop1 < 255) drop1++; end
      end
      ns1 = fir_valid ? ns1 + int'(ns_now) : 0;

      m_dvd = data_valid;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Scoreboard compare, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("d2_valid", int'(ov2), int'(exp_q2.size() != 0));
    chk("d2_data",  int'(od2), (exp_q2.size() != 0) ? int'(exp_q2[0]) : 0);
    chk("d2_level", int'(lvl2), exp_q2.size());
    chk("d2_ovf",   int'(of2), int'(ovf2));
    chk("d2_drop",  int'(dc2), drop2);
    chk("d1_valid", int'(ov1), int'(exp_q1.size() != 0));
    chk("d1_data",  int'(od1), (exp_q1.size() != 0) ? int'(exp_q1[0]) : 0);
    chk("d1_level", int'(lvl1), exp_q1.size());
    chk("d1_ovf",   int'(of1), int'(ovf1));
    chk("d1_drop",  int'(dc1), drop1);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe now, present the settled result next cycle; returns after the push edge.
  task automatic strobe(input logic [15:0] v);
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    fir_d = v;
    cyc();
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", int'(ov2), 0);
    chk("rst_data",  int'(od2), 0);
    chk("rst_level", int'(lvl2), 0);
    chk("rst_ovf",   int'(of2), 0);
    chk("rst_drop",  int'(dc2), 0);
    rst = 1'b0;
    cyc();

    // Decimation by 2 with an always-ready consumer.
    fir_valid = 1'b1;
    out_ready = 1'b1;
    strobe(16'd100);
    chk("dec_100_valid", int'(ov2), 1);
    chk("dec_100_data",  int'(od2), 100);
    strobe(16'd200);
    chk("dec_200_skip", int'(ov2), 0);
    chk("d1_200_data",  int'(od1), 200);
    strobe(16'd300);
    chk("dec_300_data", int'(od2), 300);
    strobe(16'd400);
    chk("dec_400_skip", int'(ov2), 0);
    cyc();
    out_ready = 1'b0;

    // Phase forced to 0 while fir_valid is low.
    strobe(16'd555);
    fir_valid = 1'b0;
    repeat (32) begin
      data_valid = 1'b1;
      fir_d = 16'($urandom);
      cyc();
    end
    data_valid = 1'b0;
    cyc();
    chk("fill_no_push", int'(lvl2), 1);
    fir_valid = 1'b1;
    strobe(16'h1234);
    chk("fill_first_kept_d2", int'(lvl2), 2);
    chk("fill_first_kept_d1", int'(lvl1), 2);

    // Overflow with a stalled consumer.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      data_valid = (c < 10);
      if (c >= 1) fir_d = 16'(1000 + c - 1);
      cyc();
    end
    data_valid = 1'b0;
    chk("ovf_level", int'(lvl1), 8);
    chk("ovf_flag",  int'(of1), 1);
    chk("ovf_drop",  int'(dc1), 2);
    chk("ovf_head",  int'(od1), 1000);
    chk("ovf_d2_level", int'(lvl2), 5);

    // Push and pop together while full.
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    fir_d = 16'd2000;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("full_pp_level", int'(lvl1), 8);
    chk("full_pp_drop",  int'(dc1), 2);
    chk("full_pp_head",  int'(od1), 1001);
    chk("full_pp_d2_head", int'(od2), 1002);
    out_ready = 1'b1;
    cyc(3);
    out_ready = 1'b0;
    chk("drain_level", int'(lvl1), 5);

    // clr wins over a simultaneous push.
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    fir_d = 16'd3000;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_level", int'(lvl1), 0);
    chk("clr_valid", int'(ov1), 0);
    chk("clr_ovf",   int'(of1), 0);
    chk("clr_drop",  int'(dc1), 0);

    // Asynchronous reset mid-stream.
    strobe(16'd11);
    strobe(16'd22);
    strobe(16'd33);
    chk("pre_rst_level", int'(lvl1), 3);
    data_valid = 1'b1;
    fir_d = 16'($urandom);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", int'(ov1), 0);
    chk("rst_async_level", int'(lvl1), 0);
    data_valid = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc();
    strobe(16'h7777);
    chk("post_rst_d1", int'(od1), 16'h7777);
    chk("post_rst_d2", int'(od2), 16'h7777);
    chk("post_rst_lvl", int'(lvl1), 1);

    // Randomized traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      data_valid = 1'($urandom_range(0, 1));
      fir_valid  = ($urandom_range(0, 15) != 0);
      fir_d      = 16'($urandom);
      case ((i / 500) % 3)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = ($urandom_range(0, 7) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      clr = ($urandom_range(0, 299) == 0);
      cyc();
    end
    clr = 1'b0;
    data_valid = 1'b0;
    out_ready = 1'b1;
    cyc(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
